seq_sum_n: RTL and testbench
============================

// Module: seq_sum_n
// PURPOSE
//   Parametrised multi-cycle digit-serial adder/subtractor. Processes DIGIT bits per clock, LSB first,
//   and reports a registered WIDTH-bit result, carry-out and signed overflow through a start/done handshake.
//   Successor to the fixed 5-bit combinational adder: scales to any width, trades latency for area, and adds a subtract mode.
// PARAMETERS
//   WIDTH   5   operand/result width in bits (>=1)
//   DIGIT   1   bits processed per cycle (1..WIDTH); NSTEPS = ceil(WIDTH/DIGIT)
// PORTS
//   clk    in   1      rising-edge clock, single clock domain
//   rst    in   1      synchronous reset, active-high
//   start  in   1      request; sampled only when busy=0
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   ci     in   1      carry-in (add) / borrow-in (sub), captured on accepted start
//   sub    in   1      0: a+b+ci   1: a-b-ci; captured on accepted start
//   busy   out  1      high while state=RUN
//   done   out  1      one-cycle pulse when sum/co/ovf are updated
//   sum    out  WIDTH  result, held until next completion
//   co     out  1      carry-out of bit WIDTH-1 (sub mode: 1 = no borrow)
//   ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, sum=0, co=0, ovf=0; step counter and internal carry cleared.
//   Reset has priority over everything; a reset mid-RUN aborts the operation, no done pulse, outputs go to 0.
//   FSM states:
//     IDLE -> RUN   on start=1
//     RUN  -> RUN   while step < NSTEPS-1
//     RUN  -> DONE  on the edge that processes step NSTEPS-1
//     DONE -> RUN   if start=1 (back-to-back accept)
//     DONE -> IDLE  otherwise
//   Start acceptance:
//     - Accepted in IDLE or DONE; ignored while busy (RUN). No queuing.
//     - On accept: latch a; latch b ^ {WIDTH{sub}}; latch carry = sub ? ~ci : ci; step=0.
//   Datapath:
//     - Each RUN edge adds digit[step] of both operands plus the running carry.
//     - Result digit is stored; carry is registered for the next step.
//     - Final digit when WIDTH%DIGIT != 0: upper bits are don't-care padding.
//       co and ovf are taken at bit WIDTH-1, never from the padding.
//   Outputs:
//     - sum/co/ovf load from the working registers on the RUN->DONE edge only; otherwise stable.
//     - done=1 exactly while state=DONE, i.e. NSTEPS edges after the accepting edge.
//   Arithmetic: modulo 2^WIDTH; sum equals (a + (sub ? ~b : b) + (sub ? ~ci : ci)) mod 2^WIDTH.
//   Inputs a/b/ci/sub may change freely after the accepting edge without affecting the operation.
// TESTING
//   1. W=5,D=1: a=00001 b=00010 ci=0 sub=0 -> done 5 edges after start, sum=00011 co=0 ovf=0.
//   2. W=5,D=1: 10101+01010+1 -> sum=00000 co=1 ovf=0; 11111+11111+1 -> sum=11111 co=1 ovf=0.
//   3. W=5,D=1: 01111+00001 ci=0 -> sum=10000 co=0 ovf=1. Sub 00011-00101 ci=0 -> sum=11110 co=0 ovf=0.
//   4. W=5,D=2 (NSTEPS=3): 11111+00001 -> done 3 edges after start, sum=00000 co=1. Start asserted in the DONE cycle
//      is accepted; a second done pulse follows 3 edges later.
//   5. start pulsed while busy -> ignored, result unchanged. rst at step 2 -> busy=0, no done, sum=0; new start then works.
//   6. Randomised: W in {5,8,13}, D in {1,3,W}, 1000 ops vs behavioural a+b+ci / a-b-ci; check sum, co, ovf and latency.

Source files
------------

// File: rtl/seq_sum_n.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, LSB first, with a start/done handshake.
// Result, carry-out and signed overflow are registered and held until the next completion.
module seq_sum_n #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned NSTEPS = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int unsigned PW     = NSTEPS * DIGIT;
  localparam int unsigned SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  // Position of result bit WIDTH-1 inside the final digit; bits above it are padding.
  localparam int unsigned MSBPOS = WIDTH - 1 - (NSTEPS - 1) * DIGIT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [SW-1:0]   step;
  logic            carry;
  logic [PW-1:0]   a_r;
  logic [PW-1:0]   b_r;
  logic [PW-1:0]   res_r;

  logic [DIGIT:0]   cv;
  logic [DIGIT-1:0] dsum;
  logic [PW-1:0]    res_next;
  logic             last_step;

  // Ripple add of the current digit; cv[i] is the carry into bit i of the digit.
  always_comb begin
    cv   = '0;
    dsum = '0;
    cv[0] = carry;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dsum[i]  = a_r[i] ^ b_r[i] ^ cv[i];
      cv[i+1]  = (a_r[i] & b_r[i]) | (cv[i] & (a_r[i] ^ b_r[i]));
    end
  end

  assign res_next  = PW'({dsum, res_r} >> DIGIT);
  assign last_step = (step == SW'(NSTEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
      step  <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction as a + ~b + ~ci: invert B and the borrow once at accept time.
            a_r   <= PW'(a);
            b_r   <= PW'(b ^ {WIDTH{sub}});
            carry <= sub ? ~ci : ci;
            step  <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          res_r <= res_next;
          carry <= cv[DIGIT];
          step  <= step + SW'(1);
          if (last_step) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= res_next[WIDTH-1:0];
            co    <= cv[MSBPOS+1];
            ovf   <= cv[MSBPOS] ^ cv[MSBPOS+1];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sum_n.sv
// Bench for seq_sum_n: several WIDTH/DIGIT instances, directed and random operations,
// expected results queued at issue time and checked by a per-instance monitor.
module tb_seq_sum_n;

  localparam int NCFG = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int n_fin  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cfg_w(int i);
    case (i)
      0, 1, 2, 3: return 5;
      4, 5, 6:    return 8;
      default:    return 13;
    endcase
  endfunction

  function automatic int cfg_d(int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 5;
      4: return 1;
      5: return 3;
      6: return 8;
      7: return 1;
      8: return 3;
      default: return 13;
    endcase
  endfunction

  for (genvar G = 0; G < NCFG; G++) begin : g_cfg
    localparam int W  = cfg_w(G);
    localparam int D  = cfg_d(G);
    localparam int NS = (W + D - 1) / D;

    typedef struct {
      logic [W-1:0] sum;
      logic         co;
      logic         ovf;
      int           cyc;
    } exp_t;

    exp_t q[$];

    logic         rst, start, ci, sub;
    logic [W-1:0] a, b;
    logic         busy, done, co, ovf;
    logic [W-1:0] sum;

    logic [W-1:0] h_sum = '0;
    logic         h_co  = 1'b0;
    logic         h_ovf = 1'b0;
    exp_t         e_m;

    seq_sum_n #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .ci   (ci),
      .sub  (sub),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .co   (co),
      .ovf  (ovf)
    );

    function automatic exp_t mk(logic [W-1:0] s, logic c, logic o);
      exp_t e;
      e.sum = s;
      e.co  = c;
      e.ovf = o;
      e.cyc = 0;
      return e;
    endfunction

    // Reference: plain integer a+b+ci or a-b-ci, unsigned for sum/co, signed range for ovf.
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic c, logic s);
      exp_t   e;
      longint ux, uy, sx, sy, ru, rs;
      ux = longint'(x);
      uy = longint'(y);
      sx = x[W-1] ? ux - (longint'(1) << W) : ux;
      sy = y[W-1] ? uy - (longint'(1) << W) : uy;
      if (!s) begin
        ru = ux + uy + longint'(c);
        rs = sx + sy + longint'(c);
        e.co = (ru >= (longint'(1) << W));
      end else begin
        ru = ux - uy - longint'(c);
        rs = sx - sy - longint'(c);
        e.co = (ru >= 0);
      end
      e.sum = W'(ru);
      e.ovf = (rs > (longint'(1) << (W - 1)) - 1) || (rs < -(longint'(1) << (W - 1)));
      e.cyc = 0;
      return e;
    endfunction

    function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
        0:       return '0;
        1:       return '1;
        2:       return W'(1) << (W - 1);
        default: return W'($urandom);
      endcase
    endfunction

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    // Accept one operation; while it runs, inputs are scrambled and start may pulse (ignored).
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici,
                         input logic isub, input exp_t e, input bit junk);
      exp_t ee;
      a = ia; b = ib; ci = ici; sub = isub; start = 1'b1;
      @(posedge clk);
      #1;
      ee = e;
      ee.cyc = cyc + NS;
      q.push_back(ee);
      for (int k = 0; k < NS; k++) begin
        start = junk && ($urandom_range(0, 2) == 0);
        a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        @(posedge clk);
        #1;
      end
      start = 1'b0;
    endtask

    // Monitor: pops one expectation per done pulse; otherwise outputs must hold.
    always @(negedge clk) begin
      if (rst) begin
        h_sum = '0;
        h_co  = 1'b0;
        h_ovf = 1'b0;
      end else if (done) begin
        if (q.size() == 0) begin
          check($sformatf("cfg%0d spurious_done", G), 32'(done), 32'd0);
        end else begin
          e_m = q.pop_front();
          check($sformatf("cfg%0d sum", G), 32'(sum), 32'(e_m.sum));
          check($sformatf("cfg%0d co", G), 32'(co), 32'(e_m.co));
          check($sformatf("cfg%0d ovf", G), 32'(ovf), 32'(e_m.ovf));
          check($sformatf("cfg%0d latency_cycle", G), 32'(cyc), 32'(e_m.cyc));
          h_sum = e_m.sum;
          h_co  = e_m.co;
          h_ovf = e_m.ovf;
        end
      end else begin
        check($sformatf("cfg%0d hold", G), 32'({sum, co, ovf}), 32'({h_sum, h_co, h_ovf}));
      end
    end

    initial begin
      logic [W-1:0] ra, rb;
      logic         rci, rsub;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check($sformatf("cfg%0d reset_busy", G), 32'(busy), 32'd0);
      check($sformatf("cfg%0d reset_done", G), 32'(done), 32'd0);
      check($sformatf("cfg%0d reset_out", G), 32'({sum, co, ovf}), 32'd0);

      if (G == 0) begin
        issue(W'(5'b00001), W'(5'b00010), 1'b0, 1'b0, mk(W'(5'b00011), 1'b0, 1'b0), 1'b0);
        idle(1);
        issue(W'(5'b10101), W'(5'b01010), 1'b1, 1'b0, mk(W'(5'b00000), 1'b1, 1'b0), 1'b0);
        issue(W'(5'b11111), W'(5'b11111), 1'b1, 1'b0, mk(W'(5'b11111), 1'b1, 1'b0), 1'b0);
        idle(2);
        issue(W'(5'b01111), W'(5'b00001), 1'b0, 1'b0, mk(W'(5'b10000), 1'b0, 1'b1), 1'b0);
        idle(1);
        issue(W'(5'b00011), W'(5'b00101), 1'b0, 1'b1, mk(W'(5'b11110), 1'b0, 1'b0), 1'b0);
        idle(1);
        // start pulsed mid-run must not disturb the running operation
        a = W'(1); b = W'(1); ci = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{W'(2), 1'b0, 1'b0, cyc + NS});
        start = 1'b0;
        idle(1);
        check("cfg0 busy_in_run", 32'(busy), 32'd1);
        a = W'(9); b = W'(9); start = 1'b1;
        idle(1);
        start = 1'b0;
        idle(NS - 2);
        idle(2);
        // reset on the edge that would process step 2 aborts the operation
        a = W'(3); b = W'(4); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("cfg0 abort_busy", 32'(busy), 32'd0);
        check("cfg0 abort_done", 32'(done), 32'd0);
        check("cfg0 abort_sum", 32'(sum), 32'd0);
        idle(NS);
        issue(W'(6), W'(7), 1'b1, 1'b0, mk(W'(14), 1'b0, 1'b0), 1'b0);
        idle(1);
      end

      if (G == 1) begin
        issue(W'(5'b11111), W'(5'b00001), 1'b0, 1'b0, mk(W'(5'b00000), 1'b1, 1'b0), 1'b0);
        issue(W'(5'b00010), W'(5'b00011), 1'b1, 1'b0, mk(W'(5'b00110), 1'b0, 1'b0), 1'b0);
        idle(1);
      end

      for (int n = 0; n < 100; n++) begin
        ra   = pick();
        rb   = pick();
        rci  = 1'($urandom);
        rsub = 1'($urandom);
        issue(ra, rb, rci, rsub, model(ra, rb, rci, rsub), 1'b1);
        idle($urandom_range(0, 3));
      end

      for (int t = 0; t < 100 && q.size() != 0; t++) idle(1);
      check($sformatf("cfg%0d drained", G), 32'(q.size()), 32'd0);
      n_fin++;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && n_fin < NCFG; t++) @(posedge clk);
    check("all_configs_finished", 32'(n_fin), 32'(NCFG));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
